// File: rtl/dffq_pipe.sv
// DEPTH-stage register pipeline with valid/ready handshake, bubble collapsing,
// synchronous flush and a registered occupancy count.
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

module dffq_pipe #(
    parameter int WIDTH = `BIT_DATA,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             IN_READY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] COUNT
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] vp;
    logic [WIDTH-1:0] dp [DEPTH];
    logic [DEPTH:0]   r;
    logic [CNT_W-1:0] count;
    logic             in_xfer;
    logic             out_xfer;

    // Predecessor of each stage; stage 0 is fed straight from the upstream port.
    assign vp[0] = IN_VALID;
    assign dp[0] = IN_DATA;
    for (genvar i = 1; i < DEPTH; i++) begin : g_prev
        assign vp[i] = v[i-1];
        assign dp[i] = d[i-1];
    end

    // Ready ripples backwards from the output; an empty stage is always ready,
    // which is what lets data close up bubbles while the output is stalled.
    always_comb begin
        logic acc;
        acc = OUT_READY;
        r   = '0;
        r[DEPTH] = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc  = ~v[i] | acc;
            r[i] = acc;
        end
    end

    assign in_xfer  = IN_VALID & r[0];
    assign out_xfer = v[DEPTH-1] & OUT_READY;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (FLUSH) begin
            v     <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= vp[i];
                    // Data only moves with a valid word behind it to limit toggling.
                    if (vp[i]) begin
                        d[i] <= dp[i];
                    end
                end
            end
            count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    assign IN_READY  = r[0];
    assign OUT_VALID = v[DEPTH-1];
    assign OUT_DATA  = d[DEPTH-1];
    assign COUNT     = count;

endmodule
